// File: rtl/tamagotchi_pkg.sv
// Shared types, estado encodings and per-state animation frame counts.
// Imported by the frame scheduler, its interface and its frame counter.
package tamagotchi_pkg;

  typedef logic [4:0] estado_t;
  typedef logic [9:0] addr_t;
  typedef logic [2:0] frame_t;

  localparam estado_t EST_INTRO      = 5'b00000;
  localparam estado_t EST_IDLE       = 5'b00001;
  localparam estado_t EST_DORMINDO   = 5'b00010;
  localparam estado_t EST_COMENDO    = 5'b00100;
  localparam estado_t EST_DANDO_AULA = 5'b01000;
  localparam estado_t EST_MORTO      = 5'b10000;

  // 128x64 monochrome image, one bit per pixel
  localparam int IMG_BYTES_DEF = 1024;

  typedef enum logic [1:0] {
    S_WAIT,
    S_FETCH,
    S_SEND,
    S_DONE
  } sched_state_t;

  // Animation length per state; malformed estado falls back to IDLE
  function automatic logic [3:0] frame_count(estado_t e);
    logic [3:0] n;
    case (e)
      EST_INTRO:      n = 4'd1;
      EST_IDLE:       n = 4'd6;
      EST_DORMINDO:   n = 4'd4;
      EST_COMENDO:    n = 4'd5;
      EST_DANDO_AULA: n = 4'd7;
      EST_MORTO:      n = 4'd8;
      default:        n = 4'd6;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/frame_scheduler_if.sv
// Display-side byte stream: address/frame/state to the image controller,
// byte_valid/byte_ready handshake with the display driver.
interface frame_scheduler_if;
  import tamagotchi_pkg::*;

  addr_t   byte_counter;
  frame_t  frame_index;
  estado_t estado_lat;
  logic    byte_valid;
  logic    byte_ready;

  modport master (
    output byte_counter,
    output frame_index,
    output estado_lat,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_counter,
    input  frame_index,
    input  estado_lat,
    input  byte_valid,
    output byte_ready
  );

endinterface

// File: rtl/anim_frame_counter.sv
// Step counter and animation frame index; advances once per REFRESH_PER_STEP
// refreshes. Ports: clk, reset, clear, step, estado, frame_index. ANIM_HOLD_LAST_EN.
module anim_frame_counter
  import tamagotchi_pkg::*;
#(
  parameter int REFRESH_PER_STEP = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    clear,
  input  logic    step,
  input  estado_t estado,
  output frame_t  frame_index
);

  localparam logic [7:0] STEP_LAST = 8'(REFRESH_PER_STEP - 1);

  logic [7:0] step_q;
  logic [3:0] n_frames;
  logic       last_fr;
  frame_t     fr_nx;

  assign n_frames = frame_count(estado);
  assign last_fr  = {1'b0, frame_index} >= (n_frames - 4'd1);

  always_comb begin
    fr_nx = frame_index + 3'd1;
    if (last_fr) begin
`ifdef ANIM_HOLD_LAST_EN
      // the death animation freezes on its final frame
      fr_nx = (estado == EST_MORTO) ? frame_index : '0;
`else
      fr_nx = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      step_q      <= '0;
      frame_index <= '0;
    end else if (step) begin
      if (step_q >= STEP_LAST) begin
        step_q      <= '0;
        frame_index <= fr_nx;
      end else begin
        step_q <= step_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Streams one image per start pulse to the display driver and steps the
// animation. Ports: clk, reset, estado, start, busy, frame_done, disp (bus).
// Optional: ANIM_HOLD_LAST_EN (MORTO animation holds its last frame).
module frame_scheduler
  import tamagotchi_pkg::*;
#(
  parameter int REFRESH_PER_STEP = 4,
  parameter int IMG_BYTES        = IMG_BYTES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  estado_t             estado,
  input  logic                start,
  output logic                busy,
  output logic                frame_done,
  frame_scheduler_if.master   disp
);

  localparam addr_t LAST_BYTE = addr_t'(IMG_BYTES - 1);

  sched_state_t state_q;
  sched_state_t state_d;
  logic         accept;
  logic         advance;
  logic         clear;
  logic         step;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      S_WAIT: begin
        if (start) begin
          state_d = S_FETCH;
          accept  = 1'b1;
        end
      end
      // one cycle for the image controller's registered read
      S_FETCH: state_d = S_SEND;
      S_SEND: begin
        if (disp.byte_ready) begin
          if (disp.byte_counter == LAST_BYTE) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            advance = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_WAIT;
      disp.byte_counter <= '0;
      disp.estado_lat   <= EST_INTRO;
      disp.byte_valid   <= 1'b0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
    end else begin
      state_q         <= state_d;
      disp.byte_valid <= (state_d == S_SEND);
      busy            <= (state_d != S_WAIT);
      frame_done      <= (state_d == S_DONE);
      if (accept) begin
        disp.estado_lat   <= estado;
        disp.byte_counter <= '0;
      end else if (advance) begin
        disp.byte_counter <= disp.byte_counter + addr_t'(1);
      end
    end
  end

  // a new state restarts its animation from frame 0
  assign clear = accept && (estado != disp.estado_lat);
  assign step  = (state_q == S_DONE);

  anim_frame_counter #(
    .REFRESH_PER_STEP(REFRESH_PER_STEP)
  ) u_anim (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .step        (step),
    .estado      (disp.estado_lat),
    .frame_index (disp.frame_index)
  );

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter REFRESH_PER_STEP, default 4: completed display refreshes per animation-frame advance (1..255).
REQ-002 SHALL have parameter IMG_BYTES, default 1024: bytes per image (128x64 mono).
REQ-003 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port estado, input, 5: one-hot game state (INTRO=00000, IDLE=00001, DORMINDO=00010, COMENDO=00100, DANDO_AULA=01000, MORTO=10000).
REQ-006 SHALL have port start, input, 1: refresh request, one-cycle pulse.
REQ-007 SHALL have port byte_ready, input, 1: display driver accepts current byte.
REQ-008 SHALL have port byte_counter, output, 10: byte address to image controller.
REQ-009 SHALL have port frame_index, output, 3: animation frame to image controller.
REQ-010 SHALL have port estado_lat, output, 5: estado latched for current refresh.
REQ-011 SHALL have port byte_valid, output, 1: data_to_send valid for driver.
REQ-012 SHALL have ports busy, output, 1 (refresh in progress) and frame_done, output, 1 (one-cycle pulse at refresh end).

Function
REQ-013 SHALL implement FSM WAIT, FETCH, SEND, DONE; all outputs registered.
REQ-014 SHALL, in WAIT with start=1, latch estado into estado_lat, set byte_counter=0, go FETCH; start in any other state SHALL be ignored.
REQ-015 SHALL hold FETCH exactly one cycle (covers the image controller's 1-cycle registered read), then go SEND.
REQ-016 SHALL assert byte_valid only in SEND and hold byte_counter, frame_index, estado_lat stable until byte_ready=1.
REQ-017 SHALL, in SEND with byte_ready=1: if byte_counter=IMG_BYTES-1 go DONE, else increment byte_counter and go FETCH; first byte_valid appears 2 cycles after start accepted.
REQ-018 SHALL, in DONE, pulse frame_done for one cycle, update step/frame counters, return to WAIT.
REQ-019 SHALL set busy=1 in FETCH, SEND, DONE; busy=0 in WAIT.
REQ-020 SHALL keep a step counter; in DONE it increments, and on reaching REFRESH_PER_STEP clears and advances frame_index.
REQ-021 SHALL wrap frame_index to 0 after the last frame of estado_lat: INTRO 1, IDLE 6, DORMINDO 4, COMENDO 5, DANDO_AULA 7, MORTO 8 frames; non-one-hot estado uses IDLE count.
REQ-022 SHALL, when latched estado differs from previous refresh's estado_lat, clear frame_index and step counter in the same cycle as latching.
REQ-023 SHALL ignore estado changes during a refresh (no tearing); they take effect at next accepted start.

Reset
REQ-024 SHALL on reset: FSM=WAIT, byte_counter=0, frame_index=0, step counter=0, estado_lat=INTRO, byte_valid=0, busy=0, frame_done=0.
REQ-025 SHALL abort any refresh in progress when reset asserts mid-frame; byte_valid low the cycle after reset sampled.

Configuration
REQ-026 SHALL honour macro ANIM_HOLD_LAST_EN: defined -> MORTO frame_index saturates at 7 instead of wrapping; undefined -> MORTO wraps like other states.

Structure
REQ-027 SHALL take estado encodings, per-state frame counts and IMG_BYTES default from shared package tamagotchi_pkg.
REQ-028 SHALL place step counter plus frame_index wrap/saturate logic in sub-module anim_frame_counter.

Verification
REQ-029 Reset, start at cycle 5, byte_ready=1 constant -> byte_valid first at cycle 7, 1024 bytes, frame_done once, busy low after.
REQ-030 estado=IDLE, REFRESH_PER_STEP=4, 24 refreshes -> frame_index sequence 0x4,1x4,...,5x4, then 0 on 25th.
REQ-031 byte_ready low 10 cycles at byte 500 -> byte_counter held at 500, byte_valid held high, no byte lost.
REQ-032 estado IDLE->COMENDO mid-refresh at frame_index=3 -> current refresh stays IDLE/3; next refresh estado_lat=COMENDO, frame_index=0.
REQ-033 estado=MORTO, 40 refreshes: with ANIM_HOLD_LAST_EN frame_index stops at 7; without, wraps to 0 after 32nd refresh.
REQ-034 Reset at byte 300 -> next cycle byte_valid=0, busy=0, byte_counter=0; start mid-refresh ignored.
